// File: rtl/reg_expr_pipe_ctrl_pkg.sv
// Shared constants for the two-stage register-expression pipeline controller.
package reg_expr_pipe_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned CNT_WIDTH_DEF  = 16;
    localparam int unsigned INC_VAL        = 1;

endpackage

// File: rtl/reg_expr_pipe_ctrl_pipe_stage_vld.sv
// One pipeline valid bit with its ready/load handshake; the data register lives in the parent.
module pipe_stage_vld (
    input  logic clk,
    input  logic rst,
    input  logic up_vld,
    input  logic dn_rd,
    input  logic flush,
    output logic vld,
    output logic up_rd,
    output logic ld
);

    logic vld_q;
    logic vld_d;

    // Ready, load and next valid state; a stalled stage keeps its valid bit.
    always_comb begin
        up_rd = !vld_q || dn_rd;
        ld    = up_vld && up_rd && !flush;
        if (flush) begin
            vld_d = 1'b0;
        end else begin
            vld_d = ld || (vld_q && !dn_rd);
        end
    end

    // Valid bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign vld = vld_q;

endmodule

// File: rtl/reg_expr_pipe_ctrl.sv
// Valid/ready controller sequencing r0 = i + 1 and r1 = (r0 ^ 1) + 1 + r0,
// with flush, occupancy and a wrapping count of completed output transfers.
module reg_expr_pipe_ctrl
    import reg_expr_pipe_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_vld,
    output logic                  din_rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic                  dout_rd,
    input  logic                  flush,
    output logic                  busy,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  processed_cnt
);

    localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(INC_VAL);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

    logic                  v0;
    logic                  v1;
    logic                  rdy0;
    logic                  rdy1;
    logic                  ld0;
    logic                  ld1;
    logic [DATA_WIDTH-1:0] r0_q;
    logic [DATA_WIDTH-1:0] r0_d;
    logic [DATA_WIDTH-1:0] r1_q;
    logic [DATA_WIDTH-1:0] r1_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;

    pipe_stage_vld u_stage0 (
        .clk    (clk),
        .rst    (rst),
        .up_vld (din_vld),
        .dn_rd  (rdy1),
        .flush  (flush),
        .vld    (v0),
        .up_rd  (rdy0),
        .ld     (ld0)
    );

    pipe_stage_vld u_stage1 (
        .clk    (clk),
        .rst    (rst),
        .up_vld (v0),
        .dn_rd  (dout_rd),
        .flush  (flush),
        .vld    (v1),
        .up_rd  (rdy1),
        .ld     (ld1)
    );

    assign din_rd = rdy0 && !flush;

    // Datapath next values; the output handshake still counts during a flush.
    always_comb begin
        r0_d  = din + INC;
        r1_d  = (r0_q ^ INC) + INC + r0_q;
        if (v1 && dout_rd) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stage data registers and transfer counter; data is left stale on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_q  <= '0;
            r1_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (ld0) begin
                r0_q <= r0_d;
            end else begin
                r0_q <= r0_q;
            end
            if (ld1) begin
                r1_q <= r1_d;
            end else begin
                r1_q <= r1_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign dout          = r1_q;
    assign dout_vld      = v1;
    assign busy          = v0 || v1;
    assign occupancy     = {1'b0, v0} + {1'b0, v1};
    assign processed_cnt = cnt_q;

endmodule

// File: tb/tb_reg_expr_pipe_ctrl.sv
// Directed bench for reg_expr_pipe_ctrl (CNT_WIDTH=4 so the counter wrap is reachable).
module tb_reg_expr_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_vld;
    logic       din_rd;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rd;
    logic       flush;
    logic       busy;
    logic [1:0] occupancy;
    logic [3:0] processed_cnt;

    int n_pass = 0;
    int n_total = 0;

    reg_expr_pipe_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .din_vld       (din_vld),
        .din_rd        (din_rd),
        .dout          (dout),
        .dout_vld      (dout_vld),
        .dout_rd       (dout_rd),
        .flush         (flush),
        .busy          (busy),
        .occupancy     (occupancy),
        .processed_cnt (processed_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; din_vld = 1'b0; dout_rd = 1'b0; flush = 1'b0;

        // 1: reset
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_dout_vld", 16'(dout_vld), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_occ", 16'(occupancy), 16'h0);
        chk("rst_cnt", 16'(processed_cnt), 16'h0);
        chk("rst_din_rd", 16'(din_rd), 16'h1);
        chk("rst_dout", 16'(dout), 16'h0);

        // 2: single item 05 -> r0=06, r1=07+1+06=0E
        din = 8'h05; din_vld = 1'b1; dout_rd = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("t2_not_yet", 16'(dout_vld), 16'h0);
        tick();
        chk("t2_dout", 16'(dout), 16'h0E);
        chk("t2_vld", 16'(dout_vld), 16'h1);
        chk("t2_occ", 16'(occupancy), 16'h1);
        tick();
        chk("t2_cnt", 16'(processed_cnt), 16'h1);
        chk("t2_idle", 16'(busy), 16'h0);

        // 3: FF -> 02 (wrap), 00 -> 02, 01 -> 06, back-to-back
        din = 8'hFF; din_vld = 1'b1;
        tick();
        din = 8'h00;
        tick();
        chk("t3_dout_ff", 16'(dout), 16'h02);
        din = 8'h01;
        tick();
        din_vld = 1'b0;
        chk("t3_dout_00", 16'(dout), 16'h02);
        chk("t3_vld_00", 16'(dout_vld), 16'h1);
        chk("t3_cnt_a", 16'(processed_cnt), 16'h2);
        tick();
        chk("t3_dout_01", 16'(dout), 16'h06);
        chk("t3_cnt_b", 16'(processed_cnt), 16'h3);
        tick();
        chk("t3_cnt_c", 16'(processed_cnt), 16'h4);
        chk("t3_drained", 16'(dout_vld), 16'h0);

        // 4: backpressure, offer 01, 02, 03 with dout_rd=0
        dout_rd = 1'b0; din = 8'h01; din_vld = 1'b1;
        #1;
        chk("t4_rd_empty", 16'(din_rd), 16'h1);
        tick();
        din = 8'h02;
        tick();
        chk("t4_dout_first", 16'(dout), 16'h06);
        din = 8'h03;
        #1;
        chk("t4_rd_full", 16'(din_rd), 16'h0);
        tick();
        chk("t4_occ", 16'(occupancy), 16'h2);
        chk("t4_hold_a", 16'(dout), 16'h06);
        tick();
        chk("t4_hold_b", 16'(dout), 16'h06);
        chk("t4_cnt_stall", 16'(processed_cnt), 16'h4);
        dout_rd = 1'b1;
        #1;
        chk("t4_rd_release", 16'(din_rd), 16'h1);
        tick();
        din_vld = 1'b0;
        chk("t4_seq_b", 16'(dout), 16'h06);
        chk("t4_seq_b_vld", 16'(dout_vld), 16'h1);
        tick();
        chk("t4_seq_c", 16'(dout), 16'h0A);
        tick();
        chk("t4_cnt_end", 16'(processed_cnt), 16'h7);
        chk("t4_empty", 16'(dout_vld), 16'h0);

        // 5: flush with both stages full; r0=11 -> r1=10+1+11=22
        dout_rd = 1'b0; din = 8'h10; din_vld = 1'b1;
        tick();
        din = 8'h20;
        tick();
        chk("t5_occ_full", 16'(occupancy), 16'h2);
        flush = 1'b1; dout_rd = 1'b1; din = 8'h30;
        #1;
        chk("t5_din_rd_flush", 16'(din_rd), 16'h0);
        tick();
        flush = 1'b0; din_vld = 1'b0; dout_rd = 1'b0;
        chk("t5_occ", 16'(occupancy), 16'h0);
        chk("t5_busy", 16'(busy), 16'h0);
        chk("t5_cnt", 16'(processed_cnt), 16'h8);
        chk("t5_stale", 16'(dout), 16'h22);

        // 6: 17 streamed items with a 4-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cnt_clr", 16'(processed_cnt), 16'h0);
        din_vld = 1'b1; dout_rd = 1'b1;
        for (int k = 0; k < 17; k++) begin
            din = 8'(k);
            tick();
        end
        din_vld = 1'b0;
        tick();
        chk("t6_cnt_wrap0", 16'(processed_cnt), 16'h0);
        chk("t6_last_dout", 16'(dout), 16'h22);
        tick();
        chk("t6_cnt_wrap1", 16'(processed_cnt), 16'h1);
        chk("t6_drained", 16'(busy), 16'h0);

        // mid-stream reset clears both valids
        dout_rd = 1'b0; din = 8'h40; din_vld = 1'b1;
        tick(); tick();
        chk("t6_occ_pre", 16'(occupancy), 16'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0; din_vld = 1'b0;
        chk("t6_rst_occ", 16'(occupancy), 16'h0);
        chk("t6_rst_vld", 16'(dout_vld), 16'h0);
        chk("t6_rst_cnt", 16'(processed_cnt), 16'h0);
        chk("t6_rst_dout", 16'(dout), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
